// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and requester encoding for the register file writeback path
package rf_pkg;
  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int RIDX_W = 5;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;
endpackage

// File: rtl/wb_arb2.sv
// rtl/wb_arb2.sv - two-requester writeback arbiter, one-hot grant (bit0 ALU, bit1 LSU)
// WB_RR_EN selects round-robin on contention; otherwise LSU has fixed priority.
module wb_arb2
  import rf_pkg::*;
(
`ifdef WB_RR_EN
  input  logic       clk,
  input  logic       rst,
`endif
  input  logic       i_en,
  input  logic       i_alu_valid,
  input  logic       i_lsu_valid,
  output logic [1:0] o_gnt
);

  localparam logic [1:0] GNT_ALU = 2'b01;
  localparam logic [1:0] GNT_LSU = 2'b10;

  logic w_contend;
  assign w_contend = i_en && i_alu_valid && i_lsu_valid;

`ifdef WB_RR_EN
  req_e r_ptr;

  // Pointer only moves on contested grants, toward the loser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= REQ_ALU;
    end else if (w_contend) begin
      r_ptr <= (r_ptr == REQ_ALU) ? REQ_LSU : REQ_ALU;
    end
  end

  always_comb begin
    o_gnt = 2'b00;
    if (w_contend) begin
      o_gnt = (r_ptr == REQ_ALU) ? GNT_ALU : GNT_LSU;
    end else if (i_en && i_alu_valid) begin
      o_gnt = GNT_ALU;
    end else if (i_en && i_lsu_valid) begin
      o_gnt = GNT_LSU;
    end
  end
`else
  always_comb begin
    o_gnt = 2'b00;
    if (w_contend) begin
      o_gnt = GNT_LSU;
    end else if (i_en && i_alu_valid) begin
      o_gnt = GNT_ALU;
    end else if (i_en && i_lsu_valid) begin
      o_gnt = GNT_LSU;
    end
  end
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register file write-port arbiter with RAW/WAW hazard scoreboard
// Contention policy depends on WB_RR_EN (see wb_arb2).
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int XLEN = rf_pkg::XLEN,
  parameter int NREG = rf_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [RIDX_W-1:0] iss_rs1,
  input  logic [RIDX_W-1:0] iss_rs2,
  input  logic [RIDX_W-1:0] iss_rd,
  output logic              iss_stall,
  input  logic              alu_valid,
  input  logic [RIDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_wd,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [RIDX_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_wd,
  output logic              lsu_ready,
  output logic [RIDX_W-1:0] rf_wa,
  output logic [XLEN-1:0]   rf_wd,
  output logic              rf_we,
  output logic [NREG-1:0]   busy,
  output logic              err_spurious
);

  logic [NREG-1:0]   r_busy;
  logic              r_we;
  logic [RIDX_W-1:0] r_wa;
  logic [XLEN-1:0]   r_wd;
  logic              r_err;

  logic [NREG-1:0]   w_eff_busy;
  logic [NREG-1:0]   w_busy_nxt;
  logic [1:0]        w_gnt;
  logic              w_accept;
  logic              w_write;
  logic [RIDX_W-1:0] w_g_rd;
  logic [XLEN-1:0]   w_g_wd;

  // A write landing this cycle no longer blocks readers of that register.
  always_comb begin
    w_eff_busy = r_busy;
    if (r_we) begin
      w_eff_busy[r_wa] = 1'b0;
    end
  end

  assign iss_stall = iss_valid &&
                     (w_eff_busy[iss_rs1] || w_eff_busy[iss_rs2] || w_eff_busy[iss_rd]);
  assign w_accept  = iss_valid && !iss_stall;

  wb_arb2 u_arb (
`ifdef WB_RR_EN
    .clk         (clk),
    .rst         (rst),
`endif
    .i_en        (!rst),
    .i_alu_valid (alu_valid),
    .i_lsu_valid (lsu_valid),
    .o_gnt       (w_gnt)
  );

  assign alu_ready = w_gnt[0];
  assign lsu_ready = w_gnt[1];
  assign w_g_rd    = w_gnt[1] ? lsu_rd : alu_rd;
  assign w_g_wd    = w_gnt[1] ? lsu_wd : alu_wd;
  assign w_write   = (|w_gnt) && (w_g_rd != '0);

  // Clear for the landing write first so a same-edge issue to that rd re-marks it busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_we) begin
      w_busy_nxt[r_wa] = 1'b0;
    end
    if (w_accept && (iss_rd != '0)) begin
      w_busy_nxt[iss_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_we   <= 1'b0;
      r_wa   <= '0;
      r_wd   <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_we   <= w_write;
      if (w_write) begin
        r_wa <= w_g_rd;
        r_wd <= w_g_wd;
        if (!r_busy[w_g_rd]) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign rf_we        = r_we;
  assign rf_wa        = r_wa;
  assign rf_wd        = r_wd;
  assign busy         = r_busy;
  assign err_spurious = r_err;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench: vector table, scoreboard on rf writes, corner sequences
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_stall;
  logic        alu_valid, lsu_valid;
  logic [4:0]  alu_rd, lsu_rd;
  logic [31:0] alu_wd, lsu_wd;
  logic        alu_ready, lsu_ready;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        rf_we;
  logic [31:0] busy;
  logic        err_spurious;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_stall(iss_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd), .lsu_ready(lsu_ready),
    .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we),
    .busy(busy), .err_spurious(err_spurious)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed { logic [4:0] wa; logic [31:0] wd; } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  typedef struct {
    logic        iv;
    logic [4:0]  rs1, rs2, rd;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] awd;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] lwd;
    logic        e_stall, e_ardy, e_lrdy;
    logic [31:0] e_busy;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl[NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit iv, int rs1, int rs2, int rd, bit av, int ard, int awd,
                              bit lv, int lrd, int lwd, bit es, bit ea, bit el, int eb);
    vec_t v;
    v.iv = iv; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
    v.av = av; v.ard = 5'(ard); v.awd = 32'(awd);
    v.lv = lv; v.lrd = 5'(lrd); v.lwd = 32'(lwd);
    v.e_stall = es; v.e_ardy = ea; v.e_lrdy = el; v.e_busy = 32'(eb);
    return v;
  endfunction

  task automatic idle_inputs();
    iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
    alu_valid = 0; alu_rd = 0; alu_wd = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_wd = 0;
  endtask

  task automatic drive(input vec_t v);
    iss_valid = v.iv; iss_rs1 = v.rs1; iss_rs2 = v.rs2; iss_rd = v.rd;
    alu_valid = v.av; alu_rd = v.ard; alu_wd = v.awd;
    lsu_valid = v.lv; lsu_rd = v.lrd; lsu_wd = v.lwd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int rd);
    idle_inputs();
    iss_valid = 1; iss_rd = 5'(rd);
    tick();
  endtask

  // Every rf_we outside reset must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rf_we_unexpected: got wa=%0d wd=0x%0h expected no write", rf_wa, rf_wd);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rf_wa", 64'(rf_wa), 64'(mon_e.wa));
        chk("rf_wd", 64'(rf_wd), 64'(mon_e.wd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a_rd[$];
    int l_rd[$];
    int order[4];
    int exp_order[4];
    int n_gnt;
    bit ga, gl;
`ifdef WB_RR_EN
    bit ptr_lsu;
`endif

    //        iv rs1 rs2 rd  av ard awd           lv lrd lwd     st ar lr busy
    tbl[0]  = mk(1, 0, 0, 5,  0, 0, 0,            0, 0, 0,       0, 0, 0, 'h20);
    tbl[1]  = mk(1, 5, 0, 0,  0, 0, 0,            0, 0, 0,       1, 0, 0, 'h20);
    tbl[2]  = mk(1, 0, 0, 6,  1, 5, 32'hDEADBEEF, 0, 0, 0,       0, 1, 0, 'h60);
    tbl[3]  = mk(1, 5, 0, 0,  0, 0, 0,            0, 0, 0,       0, 0, 0, 'h40);
    tbl[4]  = mk(0, 0, 0, 0,  1, 0, 'h1234,       0, 0, 0,       0, 1, 0, 'h40);
    tbl[5]  = mk(0, 0, 0, 0,  0, 0, 0,            0, 0, 0,       0, 0, 0, 'h40);
    tbl[6]  = mk(1, 0, 0, 7,  0, 0, 0,            0, 0, 0,       0, 0, 0, 'hC0);
    tbl[7]  = mk(0, 0, 0, 0,  0, 0, 0,            1, 7, 'h77,    0, 0, 1, 'hC0);
    tbl[8]  = mk(1, 7, 0, 7,  0, 0, 0,            0, 0, 0,       0, 0, 0, 'hC0);
    tbl[9]  = mk(0, 0, 0, 0,  0, 0, 0,            1, 7, 'h99,    0, 0, 1, 'hC0);
    tbl[10] = mk(0, 0, 0, 0,  1, 6, 'h66,         0, 0, 0,       0, 1, 0, 'h40);
    tbl[11] = mk(0, 0, 0, 0,  0, 0, 0,            0, 0, 0,       0, 0, 0, 'h00);
    tbl[12] = mk(1, 0, 0, 3,  0, 0, 0,            0, 0, 0,       0, 0, 0, 'h08);
    tbl[13] = mk(1, 0, 3, 4,  0, 0, 0,            0, 0, 0,       1, 0, 0, 'h08);
    tbl[14] = mk(1, 0, 0, 3,  0, 0, 0,            0, 0, 0,       1, 0, 0, 'h08);
    tbl[15] = mk(0, 3, 0, 0,  0, 0, 0,            0, 0, 0,       0, 0, 0, 'h08);
    tbl[16] = mk(0, 0, 0, 0,  1, 3, 'h33,         0, 0, 0,       0, 1, 0, 'h08);
    tbl[17] = mk(0, 0, 0, 0,  0, 0, 0,            0, 0, 0,       0, 0, 0, 'h00);

    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_we", 64'(rf_we), 0);
    chk("rst_rf_wa", 64'(rf_wa), 0);
    chk("rst_rf_wd", 64'(rf_wd), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_err", 64'(err_spurious), 0);
    chk("rst_stall", 64'(iss_stall), 0);
    chk("rst_ardy", 64'(alu_ready), 0);
    chk("rst_lrdy", 64'(lsu_ready), 0);
    rst = 0;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("stall[%0d]", i), 64'(iss_stall), 64'(tbl[i].e_stall));
      chk($sformatf("alu_ready[%0d]", i), 64'(alu_ready), 64'(tbl[i].e_ardy));
      chk($sformatf("lsu_ready[%0d]", i), 64'(lsu_ready), 64'(tbl[i].e_lrdy));
      if (tbl[i].e_ardy && tbl[i].ard != 0) exp_q.push_back({tbl[i].ard, tbl[i].awd});
      if (tbl[i].e_lrdy && tbl[i].lrd != 0) exp_q.push_back({tbl[i].lrd, tbl[i].lwd});
      tick();
      chk($sformatf("busy[%0d]", i), 64'(busy), 64'(tbl[i].e_busy));
    end
    idle_inputs();
    chk("err_clean", 64'(err_spurious), 0);

    // Spurious writeback to an idle register: flagged, sticky, still written.
    lsu_valid = 1; lsu_rd = 9; lsu_wd = 32'h0000_0909;
    @(negedge clk);
    chk("spur_lrdy", 64'(lsu_ready), 1);
    exp_q.push_back({5'd9, 32'h0000_0909});
    tick();
    idle_inputs();
    chk("err_set", 64'(err_spurious), 1);
    repeat (3) tick();
    chk("err_sticky", 64'(err_spurious), 1);

    // Contention with all four destinations in flight.
    for (int r = 10; r <= 13; r++) issue(r);
    idle_inputs();
    chk("cont_busy", 64'(busy), 64'h3C00);
    a_rd = '{10, 11};
    l_rd = '{12, 13};
    order = '{0, 0, 0, 0};
    n_gnt = 0;
`ifdef WB_RR_EN
    ptr_lsu = 0;
    exp_order = '{10, 12, 11, 13};
`else
    exp_order = '{12, 13, 10, 11};
`endif
    for (int c = 0; c < 8 && (a_rd.size() > 0 || l_rd.size() > 0); c++) begin
      alu_valid = (a_rd.size() > 0);
      alu_rd    = alu_valid ? 5'(a_rd[0]) : 5'd0;
      alu_wd    = 32'hA000_0000 | 32'(alu_rd);
      lsu_valid = (l_rd.size() > 0);
      lsu_rd    = lsu_valid ? 5'(l_rd[0]) : 5'd0;
      lsu_wd    = 32'hB000_0000 | 32'(lsu_rd);
      if (alu_valid && lsu_valid) begin
`ifdef WB_RR_EN
        ga = !ptr_lsu;
        ptr_lsu = !ptr_lsu;
`else
        ga = 0;
`endif
        gl = !ga;
      end else begin
        ga = alu_valid;
        gl = lsu_valid;
      end
      @(negedge clk);
      chk($sformatf("cont_ardy[%0d]", c), 64'(alu_ready), 64'(ga));
      chk($sformatf("cont_lrdy[%0d]", c), 64'(lsu_ready), 64'(gl));
      if (ga) exp_q.push_back({alu_rd, alu_wd});
      if (gl) exp_q.push_back({lsu_rd, lsu_wd});
      tick();
      if (alu_ready || ga) begin
        if (n_gnt < 4) order[n_gnt] = a_rd[0];
        n_gnt++;
        void'(a_rd.pop_front());
      end else if (gl) begin
        if (n_gnt < 4) order[n_gnt] = l_rd[0];
        n_gnt++;
        void'(l_rd.pop_front());
      end
    end
    idle_inputs();
    for (int k = 0; k < 4; k++) chk($sformatf("cont_order[%0d]", k), 64'(order[k]), 64'(exp_order[k]));
    repeat (2) tick();
    chk("cont_busy_done", 64'(busy), 0);

    // Reset landing in the rf_we cycle.
    for (int r = 8; r <= 11; r++) issue(r);
    idle_inputs();
    chk("pre_rst_busy", 64'(busy), 64'h0F00);
    alu_valid = 1; alu_rd = 8; alu_wd = 32'h88;
    @(negedge clk);
    chk("pre_rst_ardy", 64'(alu_ready), 1);
    tick();
    chk("pre_rst_we", 64'(rf_we), 1);
    rst = 1;
    #1;
    chk("mid_rst_we", 64'(rf_we), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_wa", 64'(rf_wa), 0);
    chk("mid_rst_wd", 64'(rf_wd), 0);
    chk("mid_rst_err", 64'(err_spurious), 0);
    chk("mid_rst_ardy", 64'(alu_ready), 0);
    tick();
    chk("in_rst_ardy", 64'(alu_ready), 0);
    rst = 0;
    #1;
    chk("post_rst_ardy", 64'(alu_ready), 1);
    idle_inputs();
    repeat (2) tick();
    chk("final_busy", 64'(busy), 0);
    chk("final_queue", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
